// File: rtl/elevator_scheduler_pkg.sv
// elevator_pkg: shared types and defaults for the elevator scheduler.
//   elev_state_t         : car state machine encoding (IDLE, MOVE, DOOR)
//   ELEV_MOVE_CYCLES_DEF : default clock cycles to travel one floor
//   ELEV_DOOR_CYCLES_DEF : default door dwell in cycles
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } elev_state_t;

  localparam int ELEV_MOVE_CYCLES_DEF = 4;
  localparam int ELEV_DOOR_CYCLES_DEF = 8;

endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: floor-request bus between a request source and the
// scheduler.
//   req_valid : request strobe, one request per cycle, no backpressure
//   req_floor : requested floor index
//   req_err   : one-cycle pulse back to the source for an out-of-range floor
// Modports: master = request source, slave = scheduler.
interface elevator_scheduler_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
);

  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_err;

  modport master (
    output req_valid,
    output req_floor,
    input  req_err
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_err
  );

endinterface

// File: rtl/elevator_scheduler_prioenco_param.sv
// prioenco_param: parametrised priority encoder.
//   vec   : request vector, WIDTH bits
//   idx   : index of the winning bit (0 when vec is empty)
//   valid : at least one bit of vec is set
// LSB_FIRST=1 picks the lowest set bit, LSB_FIRST=0 the highest.
module prioenco_param
  import elevator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan so that the preferred end is assigned last and wins.
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-style elevator controller for FLOORS floors.
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   req_if      : request bus (slave) - req_valid, req_floor in; req_err out
//   door_hold   : keeps the door open while high (ELEV_DOOR_HOLD_EN only)
//   pending     : latched unserved floor requests
//   cur_floor   : current car floor
//   tgt_floor   : next stop in the current direction (combinational)
//   tgt_valid   : a stop exists in the current direction (combinational)
//   dir_up      : travel direction, 1 = up
//   moving      : car is in MOVE
//   door_open   : car is in DOOR
//   arrive      : one-cycle pulse coinciding with each cur_floor update
// Optional feature macro: ELEV_DOOR_HOLD_EN adds the door_hold input.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = $clog2(FLOORS),
  parameter int MOVE_CYCLES = ELEV_MOVE_CYCLES_DEF,
  parameter int DOOR_CYCLES = ELEV_DOOR_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  elevator_scheduler_if.slave req_if,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOOR_W-1:0] tgt_floor,
  output logic               tgt_valid,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic               arrive
);

  localparam int MV_W = $clog2(MOVE_CYCLES + 1);
  localparam int DR_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_CYCLES - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  elev_state_t        state_q, state_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic               dir_up_q, dir_up_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [MV_W-1:0]    mv_cnt_q, mv_cnt_d;
  logic [DR_W-1:0]    door_cnt_q, door_cnt_d;
  logic               arrive_q, arrive_d;
  logic               req_err_q, req_err_d;
  logic               moving_q, moving_d;
  logic               door_open_q, door_open_d;

  logic               req_ok;
  logic [FLOORS-1:0]  req_onehot;
  logic [FLOORS-1:0]  stop_vec;
  logic [FLOOR_W-1:0] next_floor;
  logic               at_end;
  logic [FLOORS-1:0]  up_vec, dn_vec;
  logic [FLOOR_W-1:0] up_idx, dn_idx;
  logic               up_vld, dn_vld;

  function automatic logic [FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  assign up_vec = pending_q & above_mask(cur_floor_q);
  assign dn_vec = pending_q & below_mask(cur_floor_q);

  prioenco_param #(
    .WIDTH     (FLOORS),
    .LSB_FIRST (1'b1),
    .IDX_W     (FLOOR_W)
  ) u_up_enc (
    .vec   (up_vec),
    .idx   (up_idx),
    .valid (up_vld)
  );

  prioenco_param #(
    .WIDTH     (FLOORS),
    .LSB_FIRST (1'b0),
    .IDX_W     (FLOOR_W)
  ) u_dn_enc (
    .vec   (dn_vec),
    .idx   (dn_idx),
    .valid (dn_vld)
  );

  assign tgt_floor = dir_up_q ? up_idx : dn_idx;
  assign tgt_valid = dir_up_q ? up_vld : dn_vld;

  always_comb begin
    req_ok     = req_if.req_valid && (int'(req_if.req_floor) < FLOORS);
    req_onehot = '0;
    if (req_ok) req_onehot[req_if.req_floor] = 1'b1;
    // A request arriving at the edge of arrival counts as a stop there.
    stop_vec   = pending_q | req_onehot;
    next_floor = dir_up_q ? (cur_floor_q + FLOOR_W'(1)) : (cur_floor_q - FLOOR_W'(1));
    at_end     = dir_up_q ? (cur_floor_q == TOP_FLOOR) : (cur_floor_q == '0);

    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    mv_cnt_d    = mv_cnt_q;
    door_cnt_d  = door_cnt_q;
    arrive_d    = 1'b0;
    req_err_d   = req_if.req_valid && !req_ok;
    pending_d   = pending_q | req_onehot;
    // The car is already serving its floor with the door open.
    if (state_q == DOOR) pending_d[cur_floor_q] = pending_q[cur_floor_q];

    case (state_q)
      IDLE: begin
        mv_cnt_d   = '0;
        door_cnt_d = '0;
        if (pending_q[cur_floor_q]) begin
          state_d                = DOOR;
          pending_d[cur_floor_q] = 1'b0;
        end else if (dir_up_q ? up_vld : dn_vld) begin
          state_d = MOVE;
        end else if (dir_up_q ? dn_vld : up_vld) begin
          dir_up_d = !dir_up_q;
          state_d  = MOVE;
        end
      end
      MOVE: begin
        if (mv_cnt_q == MV_LAST) begin
          mv_cnt_d = '0;
          if (at_end) begin
            state_d = IDLE;
          end else begin
            cur_floor_d = next_floor;
            arrive_d    = 1'b1;
            if (stop_vec[next_floor]) begin
              state_d               = DOOR;
              door_cnt_d            = '0;
              pending_d[next_floor] = 1'b0;
            end else if ((stop_vec & (dir_up_q ? above_mask(next_floor)
                                               : below_mask(next_floor))) != '0) begin
              state_d = MOVE;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          mv_cnt_d = mv_cnt_q + MV_W'(1);
        end
      end
      DOOR: begin
`ifdef ELEV_DOOR_HOLD_EN
        if (door_hold) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DR_LAST) begin
          state_d = IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DR_W'(1);
        end
`else
        if (door_cnt_q == DR_LAST) begin
          state_d = IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DR_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    moving_d    = (state_d == MOVE);
    door_open_d = (state_d == DOOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      mv_cnt_q    <= '0;
      door_cnt_q  <= '0;
      arrive_q    <= 1'b0;
      req_err_q   <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      mv_cnt_q    <= mv_cnt_d;
      door_cnt_q  <= door_cnt_d;
      arrive_q    <= arrive_d;
      req_err_q   <= req_err_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign pending        = pending_q;
  assign cur_floor      = cur_floor_q;
  assign dir_up         = dir_up_q;
  assign moving         = moving_q;
  assign door_open      = door_open_q;
  assign arrive         = arrive_q;
  assign req_if.req_err = req_err_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: self-checking bench for elevator_scheduler with
// FLOORS=10, MOVE_CYCLES=4, DOOR_CYCLES=8. Expected door stops are queued
// when requests are driven and popped when the door opens.
module tb_elevator_scheduler;

  localparam int FLOORS  = 10;
  localparam int FLOOR_W = 4;
  localparam int MOVE_C  = 4;
  localparam int DOOR_C  = 8;
`ifdef ELEV_DOOR_HOLD_EN
  localparam int DWELL_EXP = 28;
`else
  localparam int DWELL_EXP = 8;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [FLOORS-1:0]  pending;
  logic [FLOOR_W-1:0] cur_floor, tgt_floor;
  logic               tgt_valid, dir_up, moving, door_open, arrive;
`ifdef ELEV_DOOR_HOLD_EN
  logic               door_hold = 1'b0;
`endif

  elevator_scheduler_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) rif ();

  elevator_scheduler #(
    .FLOORS      (FLOORS),
    .FLOOR_W     (FLOOR_W),
    .MOVE_CYCLES (MOVE_C),
    .DOOR_CYCLES (DOOR_C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (rif),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .pending   (pending),
    .cur_floor (cur_floor),
    .tgt_floor (tgt_floor),
    .tgt_valid (tgt_valid),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int exp_q[$];

  typedef struct {
    int               floor;
    bit               err;
    logic [FLOORS-1:0] pend;
    int               tgt;
    bit               tvld;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int f);
    rif.req_valid = 1'b1;
    rif.req_floor = FLOOR_W'(f);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cur_floor"}, int'(cur_floor), 0);
    chk({tag, "_dir_up"},    int'(dir_up), 1);
    chk({tag, "_pending"},   int'(pending), 0);
    chk({tag, "_tgt_floor"}, int'(tgt_floor), 0);
    chk({tag, "_tgt_valid"}, int'(tgt_valid), 0);
    chk({tag, "_moving"},    int'(moving), 0);
    chk({tag, "_door_open"}, int'(door_open), 0);
    chk({tag, "_arrive"},    int'(arrive), 0);
    chk({tag, "_req_err"},   int'(rif.req_err), 0);
  endtask

  task automatic wait_floor(input int f, input int budget);
    int t = 0;
    while (int'(cur_floor) != f && t < budget) begin
      tick();
      t++;
    end
    chk("wait_floor_reached", int'(int'(cur_floor) == f), 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((moving || door_open || pending != '0) && t < budget) begin
      tick();
      t++;
    end
    chk("wait_idle_reached", int'(!moving && !door_open && pending == '0), 1);
  endtask

  // Scoreboard monitor: stop floors and arrive/cur_floor coincidence.
  logic               door_prev = 1'b0;
  logic [FLOOR_W-1:0] cur_prev = '0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (door_open && !door_prev) begin
        if (exp_q.size() == 0) begin
          chk("stop_unexpected", int'(cur_floor), -1);
        end else begin
          chk("stop_floor", int'(cur_floor), exp_q.pop_front());
        end
      end
      if (arrive || cur_floor != cur_prev)
        chk("arrive_with_floor_change", int'(arrive), int'(cur_floor != cur_prev));
    end
    door_prev = door_open;
    cur_prev  = cur_floor;
  end

  initial begin
    int dwell;
    int t;
    rif.req_valid = 1'b0;
    rif.req_floor = '0;

    tbl[0] = '{floor: 0,  err: 1'b0, pend: 10'h001, tgt: 0, tvld: 1'b0};
    tbl[1] = '{floor: 3,  err: 1'b0, pend: 10'h008, tgt: 3, tvld: 1'b1};
    tbl[2] = '{floor: 9,  err: 1'b0, pend: 10'h200, tgt: 9, tvld: 1'b1};
    tbl[3] = '{floor: 10, err: 1'b1, pend: 10'h000, tgt: 0, tvld: 1'b0};
    tbl[4] = '{floor: 15, err: 1'b1, pend: 10'h000, tgt: 0, tvld: 1'b0};

    repeat (3) tick();
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // Single-request vectors, each from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      drive_req(tbl[i].floor);
      tick();
      rif.req_valid = 1'b0;
      chk($sformatf("vec%0d_req_err", i), int'(rif.req_err), int'(tbl[i].err));
      chk($sformatf("vec%0d_pending", i), int'(pending), int'(tbl[i].pend));
      chk($sformatf("vec%0d_tgt_floor", i), int'(tgt_floor), tbl[i].tgt);
      chk($sformatf("vec%0d_tgt_valid", i), int'(tgt_valid), int'(tbl[i].tvld));
      if (tbl[i].err) begin
        tick();
        chk($sformatf("vec%0d_err_pulse_end", i), int'(rif.req_err), 0);
        chk($sformatf("vec%0d_still_idle", i), int'(moving), 0);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Floor 0 -> 3 with exact edge timing; k is the edge index after E0.
    exp_q.push_back(3);
    drive_req(3);
    for (int k = 0; k <= 22; k++) begin
      tick();
      if (k == 0) begin
        rif.req_valid = 1'b0;
        chk("trip_pending_after_e0", int'(pending), 10'h008);
        chk("trip_not_moving_e0", int'(moving), 0);
      end else begin
        chk($sformatf("trip_arrive_e%0d", k), int'(arrive),
            int'(k == 5 || k == 9 || k == 13));
        chk($sformatf("trip_cur_e%0d", k), int'(cur_floor),
            (k < 5) ? 0 : (k < 9) ? 1 : (k < 13) ? 2 : 3);
        chk($sformatf("trip_moving_e%0d", k), int'(moving), int'(k >= 1 && k <= 12));
        chk($sformatf("trip_door_e%0d", k), int'(door_open), int'(k >= 13 && k <= 20));
      end
    end
    chk("trip_pending_cleared", int'(pending), 0);

    // From 3 going up: request 6, then 1 while passing floor 4.
    exp_q.push_back(6);
    exp_q.push_back(1);
    drive_req(6);
    tick();
    rif.req_valid = 1'b0;
    wait_floor(4, 40);
    drive_req(1);
    tick();
    rif.req_valid = 1'b0;
    chk("scan_tgt_first", int'(tgt_floor), 6);
    chk("scan_tgt_valid_first", int'(tgt_valid), 1);
    chk("scan_dir_first", int'(dir_up), 1);
    t = 0;
    while (!door_open && t < 40) begin tick(); t++; end
    t = 0;
    while (!moving && t < 40) begin tick(); t++; end
    chk("scan_dir_reversed", int'(dir_up), 0);
    chk("scan_tgt_second", int'(tgt_floor), 1);
    wait_idle(100);
    chk("scan_end_floor", int'(cur_floor), 1);

    // From 1: request 7, then request 5 exactly at the arrival edge for 5.
    exp_q.push_back(5);
    exp_q.push_back(7);
    drive_req(7);
    tick();
    rif.req_valid = 1'b0;
    repeat (16) tick();
    chk("late_not_yet_at_5", int'(cur_floor), 4);
    drive_req(5);
    tick();
    rif.req_valid = 1'b0;
    chk("late_cur_floor", int'(cur_floor), 5);
    chk("late_arrive", int'(arrive), 1);
    chk("late_door_open", int'(door_open), 1);
    chk("late_pending", int'(pending), 10'h080);
    wait_idle(100);
    chk("late_end_floor", int'(cur_floor), 7);

    // Boundaries: top floor then back to floor 0.
    exp_q.push_back(9);
    drive_req(9);
    tick();
    rif.req_valid = 1'b0;
    wait_idle(100);
    chk("top_floor", int'(cur_floor), 9);
    chk("top_dir_kept", int'(dir_up), 1);
    exp_q.push_back(0);
    drive_req(0);
    tick();
    rif.req_valid = 1'b0;
    chk("top_tgt_valid_up", int'(tgt_valid), 0);
    wait_idle(100);
    chk("bottom_floor", int'(cur_floor), 0);
    chk("bottom_dir", int'(dir_up), 0);
    chk("sb_empty_mid", exp_q.size(), 0);

    // Asynchronous reset while moving at floor 2.
    drive_req(8);
    tick();
    rif.req_valid = 1'b0;
    wait_floor(2, 40);
    chk("mid_reset_moving_before", int'(moving), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Door dwell at the current floor.
    exp_q.push_back(0);
    drive_req(0);
    tick();
    rif.req_valid = 1'b0;
    tick();
    chk("dwell_door_opened", int'(door_open), 1);
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = 1'b1;
`endif
    dwell = 1;
    t = 0;
    while (door_open && t < 100) begin
`ifdef ELEV_DOOR_HOLD_EN
      if (t == 20) door_hold = 1'b0;
`endif
      tick();
      t++;
      if (door_open) dwell++;
    end
    chk("door_dwell_cycles", dwell, DWELL_EXP);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
